// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port, shared between the
// ALU result path and returning loads, plus a scoreboard of registers with loads in flight.
module regfile_wb_arbiter #(
    parameter int W      = 8,
    parameter int D      = 4,
    parameter int STARVE = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              AluValid,
    input  logic [D-1:0]      AluAddr,
    input  logic [W-1:0]      AluData,
    output logic              AluReady,
    input  logic              LdIssue,
    input  logic [D-1:0]      LdIssueAddr,
    input  logic              LdValid,
    input  logic [D-1:0]      LdAddr,
    input  logic [W-1:0]      LdData,
    output logic              LdReady,
    input  logic [D-1:0]      SrcAddrA,
    input  logic [D-1:0]      SrcAddrB,
    output logic              Stall,
    output logic              WeOut,
    output logic [D-1:0]      WaddrOut,
    output logic [W-1:0]      WdataOut,
    output logic [2**D-1:0]   BusyMask,
    output logic              Err
);

    localparam int         N          = 2**D;
    localparam logic [2:0] STARVE_CNT = 3'(STARVE);

    logic [N-1:0] busy_q, busy_d;
    logic [2:0]   wait_q, wait_d;
    logic         we_q, we_d;
    logic [D-1:0] waddr_q, waddr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         err_q, err_d;

    logic alu_elig;
    logic alu_grant;
    logic ld_grant;
    logic issue_err;
    logic return_err;

    // The ALU is held off a register with a load still in flight (WAW), and loses
    // to a pending load once that load has been denied STARVE cycles in a row.
    always_comb begin
        alu_elig  = AluValid & ~busy_q[AluAddr];
        ld_grant  = LdValid & (~alu_elig | (wait_q == STARVE_CNT));
        alu_grant = alu_elig & ~ld_grant;
    end

    always_comb begin
        wait_d = wait_q;
        if (!LdValid || ld_grant) begin
            wait_d = 3'd0;
        end else if (wait_q != STARVE_CNT) begin
            wait_d = wait_q + 3'd1;
        end
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (ld_grant) begin
            we_d    = 1'b1;
            waddr_d = LdAddr;
            wdata_d = LdData;
        end else if (alu_grant) begin
            we_d    = 1'b1;
            waddr_d = AluAddr;
            wdata_d = AluData;
        end
    end

    // The set is applied after the clear so a fresh issue to the register
    // whose load is returning this cycle keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (ld_grant) begin
            busy_d[LdAddr] = 1'b0;
        end
        if (LdIssue) begin
            busy_d[LdIssueAddr] = 1'b1;
        end
    end

    always_comb begin
        issue_err  = LdIssue & busy_q[LdIssueAddr] & ~(ld_grant & (LdAddr == LdIssueAddr));
        return_err = LdValid & ~busy_q[LdAddr];
        err_d      = err_q | issue_err | return_err;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q  <= '0;
            wait_q  <= 3'd0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign AluReady = alu_grant;
    assign LdReady  = ld_grant;
    assign Stall    = busy_q[SrcAddrA] | busy_q[SrcAddrB] | (AluValid & ~alu_grant);
    assign WeOut    = we_q;
    assign WaddrOut = waddr_q;
    assign WdataOut = wdata_q;
    assign BusyMask = busy_q;
    assign Err      = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios for each feature, then random
// traffic checked against a behavioural model of the write port and scoreboard.
module tb_regfile_wb_arbiter;

    localparam int W      = 8;
    localparam int D      = 4;
    localparam int N      = 16;
    localparam int STARVE = 2;

    logic         Clk = 1'b0;
    logic         Reset;
    logic         AluValid;
    logic [D-1:0] AluAddr;
    logic [W-1:0] AluData;
    logic         AluReady;
    logic         LdIssue;
    logic [D-1:0] LdIssueAddr;
    logic         LdValid;
    logic [D-1:0] LdAddr;
    logic [W-1:0] LdData;
    logic         LdReady;
    logic [D-1:0] SrcAddrA;
    logic [D-1:0] SrcAddrB;
    logic         Stall;
    logic         WeOut;
    logic [D-1:0] WaddrOut;
    logic [W-1:0] WdataOut;
    logic [N-1:0] BusyMask;
    logic         Err;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.W(W), .D(D), .STARVE(STARVE)) dut (
        .Clk(Clk), .Reset(Reset),
        .AluValid(AluValid), .AluAddr(AluAddr), .AluData(AluData), .AluReady(AluReady),
        .LdIssue(LdIssue), .LdIssueAddr(LdIssueAddr),
        .LdValid(LdValid), .LdAddr(LdAddr), .LdData(LdData), .LdReady(LdReady),
        .SrcAddrA(SrcAddrA), .SrcAddrB(SrcAddrB), .Stall(Stall),
        .WeOut(WeOut), .WaddrOut(WaddrOut), .WdataOut(WdataOut),
        .BusyMask(BusyMask), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // Behavioural model state
    bit mdl_busy[N];
    int mdl_wait;
    bit mdl_err;
    bit mdl_we;
    int mdl_waddr;
    int mdl_wdata;
    bit exp_alu_rdy;
    bit exp_ld_rdy;
    bit exp_stall;

    function automatic logic [N-1:0] mdl_busy_vec();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = mdl_busy[i];
        return v;
    endfunction

    task automatic model_comb();
        bit alu_ok;
        alu_ok      = AluValid && !mdl_busy[AluAddr];
        exp_ld_rdy  = LdValid && (!alu_ok || mdl_wait >= STARVE);
        exp_alu_rdy = alu_ok && !exp_ld_rdy;
        exp_stall   = mdl_busy[SrcAddrA] || mdl_busy[SrcAddrB] || (AluValid && !exp_alu_rdy);
    endtask

    task automatic model_seq();
        if (Reset) begin
            for (int i = 0; i < N; i++) mdl_busy[i] = 1'b0;
            mdl_wait = 0; mdl_err = 0; mdl_we = 0; mdl_waddr = 0; mdl_wdata = 0;
        end else begin
            if (LdValid && !mdl_busy[LdAddr]) mdl_err = 1;
            if (LdIssue && mdl_busy[LdIssueAddr] && !(exp_ld_rdy && LdAddr == LdIssueAddr)) mdl_err = 1;
            mdl_we = exp_ld_rdy || exp_alu_rdy;
            if (exp_ld_rdy) begin
                mdl_waddr = int'(LdAddr); mdl_wdata = int'(LdData);
                mdl_busy[LdAddr] = 1'b0;
            end else if (exp_alu_rdy) begin
                mdl_waddr = int'(AluAddr); mdl_wdata = int'(AluData);
            end
            if (LdIssue) mdl_busy[LdIssueAddr] = 1'b1;
            if (!LdValid || exp_ld_rdy) mdl_wait = 0;
            else mdl_wait = (mdl_wait + 1 > STARVE) ? STARVE : mdl_wait + 1;
        end
    endtask

    task automatic clk_step();
        model_comb();
        @(posedge Clk);
        model_seq();
        #1;
    endtask

    task automatic settle();
        #1;
        model_comb();
    endtask

    task automatic idle_inputs();
        Reset = 0; AluValid = 0; AluAddr = '0; AluData = '0;
        LdIssue = 0; LdIssueAddr = '0; LdValid = 0; LdAddr = '0; LdData = '0;
        SrcAddrA = '0; SrcAddrB = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset = 1;
        clk_step();
        Reset = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (WeOut !== 1'b0) begin errors++; $display("[TB] FAIL reset_we: got %b want 0", WeOut); end
        checks++; if (BusyMask !== 16'h0) begin errors++; $display("[TB] FAIL reset_busy: got %h want 0000", BusyMask); end
        checks++; if (Err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", Err); end
        // Build up state: busy r2 plus a completed ALU write to r9
        LdIssue = 1; LdIssueAddr = 4'd2;
        AluValid = 1; AluAddr = 4'd9; AluData = 8'hC3;
        clk_step();
        idle_inputs();
        checks++; if (BusyMask !== 16'h0004) begin errors++; $display("[TB] FAIL midop_busy: got %h want 0004", BusyMask); end
        checks++; if (WaddrOut !== 4'd9) begin errors++; $display("[TB] FAIL midop_waddr: got %0d want 9", WaddrOut); end
        LdValid = 1; LdAddr = 4'd2; LdData = 8'h5A; Reset = 1;
        clk_step();
        idle_inputs();
        settle();
        checks++; if (WeOut !== 1'b0) begin errors++; $display("[TB] FAIL midop_rst_we: got %b want 0", WeOut); end
        checks++; if (WaddrOut !== 4'd0) begin errors++; $display("[TB] FAIL midop_rst_waddr: got %0d want 0", WaddrOut); end
        checks++; if (WdataOut !== 8'h00) begin errors++; $display("[TB] FAIL midop_rst_wdata: got %h want 00", WdataOut); end
        checks++; if (BusyMask !== 16'h0) begin errors++; $display("[TB] FAIL midop_rst_busy: got %h want 0000", BusyMask); end
        checks++; if (Err !== 1'b0) begin errors++; $display("[TB] FAIL midop_rst_err: got %b want 0", Err); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("[TB] FAIL midop_rst_stall: got %b want 0", Stall); end
    endtask

    task automatic test_alu_only();
        do_reset();
        AluValid = 1; AluAddr = 4'd3; AluData = 8'hA5;
        settle();
        checks++; if (AluReady !== 1'b1) begin errors++; $display("[TB] FAIL alu_ready: got %b want 1", AluReady); end
        checks++; if (Stall !== 1'b0) begin errors++; $display("[TB] FAIL alu_stall: got %b want 0", Stall); end
        clk_step();
        AluValid = 0;
        checks++; if (WeOut !== 1'b1) begin errors++; $display("[TB] FAIL alu_we: got %b want 1", WeOut); end
        checks++; if (WaddrOut !== 4'd3) begin errors++; $display("[TB] FAIL alu_waddr: got %0d want 3", WaddrOut); end
        checks++; if (WdataOut !== 8'hA5) begin errors++; $display("[TB] FAIL alu_wdata: got %h want a5", WdataOut); end
        clk_step();
        checks++; if (WeOut !== 1'b0) begin errors++; $display("[TB] FAIL alu_idle_we: got %b want 0", WeOut); end
        checks++; if (WdataOut !== 8'hA5) begin errors++; $display("[TB] FAIL alu_hold_wdata: got %h want a5", WdataOut); end
    endtask

    task automatic test_starvation();
        do_reset();
        LdIssue = 1; LdIssueAddr = 4'd5;
        clk_step();
        LdIssue = 0;
        LdValid = 1; LdAddr = 4'd5; LdData = 8'h3C;
        AluValid = 1; AluAddr = 4'd9;
        for (int c = 0; c < 2; c++) begin
            AluData = 8'(8'h10 + c);
            settle();
            checks++; if (AluReady !== 1'b1 || LdReady !== 1'b0) begin errors++; $display("[TB] FAIL starve_c%0d_grant: got alu=%b ld=%b want alu=1 ld=0", c, AluReady, LdReady); end
            clk_step();
            checks++; if (WeOut !== 1'b1 || WaddrOut !== 4'd9 || WdataOut !== 8'(8'h10 + c)) begin errors++; $display("[TB] FAIL starve_c%0d_write: got we=%b a=%0d d=%h want we=1 a=9 d=%h", c, WeOut, WaddrOut, WdataOut, 8'(8'h10 + c)); end
        end
        AluData = 8'h12;
        settle();
        checks++; if (AluReady !== 1'b0 || LdReady !== 1'b1) begin errors++; $display("[TB] FAIL starve_c2_grant: got alu=%b ld=%b want alu=0 ld=1", AluReady, LdReady); end
        checks++; if (Stall !== 1'b1) begin errors++; $display("[TB] FAIL starve_c2_stall: got %b want 1", Stall); end
        clk_step();
        LdValid = 0;
        checks++; if (WeOut !== 1'b1 || WaddrOut !== 4'd5 || WdataOut !== 8'h3C) begin errors++; $display("[TB] FAIL starve_c3_write: got we=%b a=%0d d=%h want we=1 a=5 d=3c", WeOut, WaddrOut, WdataOut); end
        checks++; if (BusyMask[5] !== 1'b0) begin errors++; $display("[TB] FAIL starve_c3_busy5: got %b want 0", BusyMask[5]); end
        settle();
        checks++; if (AluReady !== 1'b1) begin errors++; $display("[TB] FAIL starve_c3_alu: got %b want 1", AluReady); end
        clk_step();
        AluValid = 0;
        checks++; if (WaddrOut !== 4'd9 || WdataOut !== 8'h12) begin errors++; $display("[TB] FAIL starve_c4_write: got a=%0d d=%h want a=9 d=12", WaddrOut, WdataOut); end
    endtask

    task automatic test_hazard();
        do_reset();
        LdIssue = 1; LdIssueAddr = 4'd1;
        clk_step();
        LdIssue = 0;
        AluValid = 1; AluAddr = 4'd1; AluData = 8'h77; SrcAddrA = 4'd1; SrcAddrB = 4'd0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++; if (AluReady !== 1'b0 || Stall !== 1'b1) begin errors++; $display("[TB] FAIL hazard_hold%0d: got ready=%b stall=%b want ready=0 stall=1", c, AluReady, Stall); end
            clk_step();
        end
        LdValid = 1; LdAddr = 4'd1; LdData = 8'h11;
        settle();
        checks++; if (LdReady !== 1'b1 || AluReady !== 1'b0 || Stall !== 1'b1) begin errors++; $display("[TB] FAIL hazard_ldgrant: got ld=%b alu=%b stall=%b want 1 0 1", LdReady, AluReady, Stall); end
        clk_step();
        LdValid = 0;
        checks++; if (BusyMask[1] !== 1'b0 || WaddrOut !== 4'd1 || WdataOut !== 8'h11) begin errors++; $display("[TB] FAIL hazard_ldwrite: got busy1=%b a=%0d d=%h want 0 1 11", BusyMask[1], WaddrOut, WdataOut); end
        settle();
        checks++; if (AluReady !== 1'b1 || Stall !== 1'b0) begin errors++; $display("[TB] FAIL hazard_release: got ready=%b stall=%b want ready=1 stall=0", AluReady, Stall); end
        clk_step();
        AluValid = 0;
        checks++; if (WeOut !== 1'b1 || WdataOut !== 8'h77) begin errors++; $display("[TB] FAIL hazard_aluwrite: got we=%b d=%h want we=1 d=77", WeOut, WdataOut); end
    endtask

    task automatic test_set_clear();
        do_reset();
        LdIssue = 1; LdIssueAddr = 4'd2;
        clk_step();
        LdValid = 1; LdAddr = 4'd2; LdData = 8'h22;
        settle();
        checks++; if (LdReady !== 1'b1) begin errors++; $display("[TB] FAIL setclr_ready: got %b want 1", LdReady); end
        clk_step();
        LdIssue = 0; LdValid = 0;
        checks++; if (BusyMask[2] !== 1'b1) begin errors++; $display("[TB] FAIL setclr_busy2: got %b want 1", BusyMask[2]); end
        checks++; if (Err !== 1'b0) begin errors++; $display("[TB] FAIL setclr_err: got %b want 0", Err); end
        checks++; if (WaddrOut !== 4'd2 || WdataOut !== 8'h22) begin errors++; $display("[TB] FAIL setclr_write: got a=%0d d=%h want a=2 d=22", WaddrOut, WdataOut); end
    endtask

    task automatic test_protocol_err();
        do_reset();
        LdValid = 1; LdAddr = 4'd7; LdData = 8'h99;
        settle();
        checks++; if (LdReady !== 1'b1) begin errors++; $display("[TB] FAIL perr_ready: got %b want 1", LdReady); end
        clk_step();
        LdValid = 0;
        checks++; if (WeOut !== 1'b1 || WaddrOut !== 4'd7 || WdataOut !== 8'h99) begin errors++; $display("[TB] FAIL perr_write: got we=%b a=%0d d=%h want 1 7 99", WeOut, WaddrOut, WdataOut); end
        checks++; if (Err !== 1'b1) begin errors++; $display("[TB] FAIL perr_ret_err: got %b want 1", Err); end
        for (int c = 0; c < 3; c++) clk_step();
        checks++; if (Err !== 1'b1) begin errors++; $display("[TB] FAIL perr_sticky: got %b want 1", Err); end
        do_reset();
        checks++; if (Err !== 1'b0) begin errors++; $display("[TB] FAIL perr_rst: got %b want 0", Err); end
        LdIssue = 1; LdIssueAddr = 4'd4;
        clk_step();
        checks++; if (Err !== 1'b0) begin errors++; $display("[TB] FAIL perr_first_issue: got %b want 0", Err); end
        clk_step();
        LdIssue = 0;
        checks++; if (Err !== 1'b1 || BusyMask[4] !== 1'b1) begin errors++; $display("[TB] FAIL perr_dup_issue: got err=%b busy4=%b want 1 1", Err, BusyMask[4]); end
    endtask

    task automatic test_random();
        bit alu_pend;
        bit ld_pend;
        int cand[$];
        alu_pend = 0;
        ld_pend  = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!alu_pend && $urandom_range(0, 9) < 6) begin
                alu_pend = 1; AluAddr = 4'($urandom); AluData = 8'($urandom);
            end
            AluValid = alu_pend;
            if (!ld_pend && $urandom_range(0, 9) < 5) begin
                cand.delete();
                for (int i = 0; i < N; i++) if (mdl_busy[i]) cand.push_back(i);
                if (cand.size() > 0) begin
                    ld_pend = 1;
                    LdAddr  = 4'(cand[$urandom_range(0, cand.size() - 1)]);
                    LdData  = 8'($urandom);
                end
            end
            LdValid = ld_pend;
            LdIssue = 0;
            if ($urandom_range(0, 9) < 3) begin
                cand.delete();
                for (int i = 0; i < N; i++) if (!mdl_busy[i]) cand.push_back(i);
                if (cand.size() > 0) begin
                    LdIssue     = 1;
                    LdIssueAddr = 4'(cand[$urandom_range(0, cand.size() - 1)]);
                end
            end
            SrcAddrA = 4'($urandom);
            SrcAddrB = 4'($urandom);
            settle();
            checks++; if (AluReady !== exp_alu_rdy) begin errors++; $display("[TB] FAIL rnd%0d_aluready: got %b want %b", c, AluReady, exp_alu_rdy); end
            checks++; if (LdReady !== exp_ld_rdy) begin errors++; $display("[TB] FAIL rnd%0d_ldready: got %b want %b", c, LdReady, exp_ld_rdy); end
            checks++; if (Stall !== exp_stall) begin errors++; $display("[TB] FAIL rnd%0d_stall: got %b want %b", c, Stall, exp_stall); end
            clk_step();
            if (exp_alu_rdy) alu_pend = 0;
            if (exp_ld_rdy) ld_pend = 0;
            checks++; if (WeOut !== mdl_we) begin errors++; $display("[TB] FAIL rnd%0d_we: got %b want %b", c, WeOut, mdl_we); end
            checks++; if (WaddrOut !== 4'(mdl_waddr) || WdataOut !== 8'(mdl_wdata)) begin errors++; $display("[TB] FAIL rnd%0d_wport: got a=%0d d=%h want a=%0d d=%h", c, WaddrOut, WdataOut, mdl_waddr, 8'(mdl_wdata)); end
            checks++; if (BusyMask !== mdl_busy_vec()) begin errors++; $display("[TB] FAIL rnd%0d_busy: got %h want %h", c, BusyMask, mdl_busy_vec()); end
            checks++; if (Err !== mdl_err) begin errors++; $display("[TB] FAIL rnd%0d_err: got %b want %b", c, Err, mdl_err); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        @(negedge Clk);
        test_reset();
        test_alu_only();
        test_starvation();
        test_hazard();
        test_set_clear();
        test_protocol_err();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and load scoreboard for the 8-bit, 16-entry register file. It shares the register file's single write port between the single-cycle ALU result path and the multi-cycle data-memory load return. It tracks which registers have loads in flight and raises a decode stall on RAW and WAW hazards against those registers. It sits between the ALU, the data-memory load unit, decode, and the register file write port.

## Interface
- W, 8, data path width
- D, 4, register pointer width (2**D registers)
- STARVE, 2, number of consecutive denied cycles after which a pending load beats the ALU (range 1..7)

- Clk  in  1  clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high; sampled on rising edge of Clk
- AluValid  in  1  ALU has a result to write
- AluAddr  in  D  ALU destination register
- AluData  in  W  ALU result
- AluReady  out  1  ALU write accepted this cycle (combinational)
- LdIssue  in  1  load issued to memory this cycle
- LdIssueAddr  in  D  destination register of issued load
- LdValid  in  1  load data returned and waiting
- LdAddr  in  D  destination register of returned load
- LdData  in  W  returned load data
- LdReady  out  1  load write accepted this cycle (combinational)
- SrcAddrA, SrcAddrB  in  D  source registers of the instruction in decode
- Stall  out  1  decode must hold (combinational)
- WeOut  out  1  register file write enable (registered)
- WaddrOut  out  D  register file write address (registered)
- WdataOut  out  W  register file write data (registered)
- BusyMask  out  2**D  bit i set = load in flight to register i (registered)
- Err  out  1  sticky protocol error (registered)

## Operation
- Eligibility:
  - ALU request eligible = AluValid & ~BusyMask[AluAddr]. A WAW hazard against an in-flight load holds the ALU.
  - Load request eligible = LdValid.
- Grant, combinational, at most one per cycle:
  - Only one eligible: it wins.
  - Both eligible: ALU wins unless WaitCnt == STARVE, then load wins.
- AluReady = ALU grant; LdReady = load grant. A requester holds valid/addr/data stable until its ready is seen.
- WaitCnt (3 bits):
  - Increments, saturating at STARVE, each cycle LdValid & ~LdReady.
  - Cleared on load grant or when LdValid = 0.
- Write port: the granted request's addr/data are registered into WaddrOut/WdataOut with WeOut=1. No grant gives WeOut=0; WaddrOut/WdataOut hold their last values.
- Scoreboard:
  - LdIssue sets BusyMask[LdIssueAddr].
  - A load grant clears BusyMask[LdAddr].
  - Set and clear of the same bit in the same cycle: set wins, since a new load is in flight.
- Stall = BusyMask[SrcAddrA] | BusyMask[SrcAddrB] | (AluValid & ~AluReady).
- Err is set, and stays set until Reset, on:
  - LdIssue to an already-busy register not being cleared that cycle;
  - LdValid with BusyMask[LdAddr] = 0.
  The offending operation is still performed: the set is a no-op; the write still happens on grant.

## Timing
- Reset values: WeOut=0, WaddrOut=0, WdataOut=0, BusyMask=0, Err=0, WaitCnt=0. Reset has priority over all updates and discards any request in progress. Combinational outputs follow from the reset state.
- Write latency: grant in cycle n gives WeOut/WaddrOut/WdataOut valid in cycle n+1. The register file commits at the end of n+1.
- BusyMask updates one cycle after LdIssue/grant. Stall reflects the registered mask.
- A register cleared by a load grant in cycle n is unstalled in n+1. Its data is written at the end of n+1, so a read issued in n+2 sees the new value. Decode does not re-read before n+2; no bypass is provided.
- Load worst-case wait with a continuously valid ALU: STARVE denied cycles, then granted on the next cycle.
- Throughput: one write per cycle, back-to-back grants allowed.

## Test plan
- Reset mid-operation: BusyMask=16'h0004, LdValid held, assert Reset one cycle -> next cycle all registered outputs 0, Err=0, Stall=0.
- ALU only: AluValid, AluAddr=3, AluData=8'hA5 -> AluReady=1 same cycle; WeOut=1, WaddrOut=3, WdataOut=8'hA5 next cycle.
- Starvation, STARVE=2:
  - Stimulus: AluValid held every cycle; LdValid from cycle 0 with LdAddr=5 (busy), LdData=8'h3C.
  - Response: ALU granted cycles 0,1; load granted cycle 2; WeOut with WaddrOut=5, WdataOut=8'h3C in cycle 3; BusyMask[5] clears cycle 3.
- WAW/RAW hazard:
  - Stimulus: LdIssue to r1, then AluValid with AluAddr=1 and SrcAddrA=1.
  - Response: AluReady=0 and Stall=1 until the r1 load is granted; AluReady=1 the cycle after BusyMask[1] clears.
- Simultaneous set/clear: load granted to r2 in the same cycle as LdIssue to r2 -> BusyMask[2] stays 1, Err=0.
- Protocol errors: LdValid with LdAddr=7 not busy -> write performed, Err=1 and sticky. Separately, LdIssue to a busy register -> Err=1.
